// File: rtl/pump_lead_lag_scheduler_pkg.sv
// Shared definitions for the pump lead/lag scheduler: FSM state codes, lead-pump
// codes, timer width and a saturating timer increment.
package pump_lead_lag_scheduler_pkg;

  localparam int unsigned TMR_W = 16;
  typedef logic [TMR_W-1:0] tmr_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLead  = 2'd1,
    StBoth  = 2'd2,
    StFault = 2'd3
  } sched_state_e;

  localparam logic LEAD_P1 = 1'b0;
  localparam logic LEAD_P2 = 1'b1;

  function automatic tmr_t tmr_inc(tmr_t t);
    return (&t) ? t : t + 1'b1;
  endfunction

endpackage

// File: rtl/pump_lead_lag_scheduler_if.sv
// Level-in / pump-out bundle of the scheduler.
//   master: level source / supervisor side (drives level, enable, fault_clr)
//   slave : scheduler side (drives pump commands and status)
interface pump_lead_lag_scheduler_if;
  logic [7:0] water_lvl;
  logic       enable;
  logic       fault_clr;
  logic       pump1;
  logic       pump2;
  logic       lead_sel;
  logic [1:0] state;
  logic       alarm;
  logic [7:0] cycle_cnt;

  modport master (
    output water_lvl, enable, fault_clr,
    input  pump1, pump2, lead_sel, state, alarm, cycle_cnt
  );

  modport slave (
    input  water_lvl, enable, fault_clr,
    output pump1, pump2, lead_sel, state, alarm, cycle_cnt
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
//   CLK100MHZ  : clock
//   CPU_RESETN : asynchronous active-low reset
//   tick       : high for one cycle when the counter wraps at DIV-1
module tick_prescaler #(
  parameter int unsigned DIV = 100000
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  output logic tick
);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pump_lead_lag_scheduler.sv
// Lead/lag pump scheduler. On each decision tick the water level is sampled and
// the FSM decides which pumps run; lead role alternates after every completed fill
// cycle and after a fault clear. Enforces minimum run/off times and a stall fault.
//   CLK100MHZ  : clock
//   CPU_RESETN : asynchronous active-low reset
//   bus        : level/enable/fault_clr in; pump1/pump2/lead_sel/state/alarm/cycle_cnt out
module pump_lead_lag_scheduler
  import pump_lead_lag_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000,
  parameter logic [7:0]  START_LVL   = 8'd64,
  parameter logic [7:0]  ASSIST_LVL  = 8'd32,
  parameter logic [7:0]  STOP_LVL    = 8'd192,
  parameter tmr_t        MIN_RUN     = 16'd500,
  parameter tmr_t        MIN_OFF     = 16'd200,
  parameter tmr_t        STALL_TICKS = 16'd2000
) (
  input  logic                       CLK100MHZ,
  input  logic                       CPU_RESETN,
  pump_lead_lag_scheduler_if.slave   bus
);
  logic tick;

  tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .tick       (tick)
  );

  sched_state_e state_q, state_d;
  tmr_t         off_q, off_d, run_q, run_d, stall_q, stall_d, stall_nx;
  logic [7:0]   lvl_q, lvl_d, ref_q, ref_d, cyc_q, cyc_d;
  logic         lead_q, lead_d;
  logic         pump1_q, pump1_d, pump2_q, pump2_d, alarm_q, alarm_d;

  always_comb begin
    // The freshly sampled level drives the decision on the same tick.
    lvl_d    = tick ? bus.water_lvl : lvl_q;
    state_d  = state_q;
    off_d    = off_q;
    run_d    = run_q;
    stall_d  = stall_q;
    ref_d    = ref_q;
    lead_d   = lead_q;
    cyc_d    = cyc_q;
    stall_nx = (lvl_d > ref_q) ? '0 : tmr_inc(stall_q);

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          off_d = tmr_inc(off_q);
          if (bus.enable && lvl_d <= START_LVL && off_q >= MIN_OFF) begin
            state_d = StLead;
            run_d   = '0;
            stall_d = '0;
            ref_d   = lvl_d;
          end
        end
        StLead, StBoth: begin
          if (!bus.enable) begin
            state_d = StIdle;
            off_d   = '0;
          end else begin
            stall_d = stall_nx;
            if (lvl_d > ref_q) ref_d = lvl_d;
            run_d = tmr_inc(run_q);
            if (stall_nx >= STALL_TICKS) begin
              state_d = StFault;
            end else if (lvl_d >= STOP_LVL && run_q >= MIN_RUN) begin
              state_d = StIdle;
              lead_d  = ~lead_q;
              cyc_d   = (&cyc_q) ? cyc_q : cyc_q + 8'd1;
              off_d   = '0;
            end else if (state_q == StLead && lvl_d <= ASSIST_LVL) begin
              state_d = StBoth;
            end else if (state_q == StBoth && lvl_d > START_LVL) begin
              state_d = StLead;
            end
          end
        end
        StFault: begin
          // Demote the pump that was lead when the stall happened.
          if (bus.fault_clr) begin
            state_d = StIdle;
            off_d   = '0;
            lead_d  = ~lead_q;
          end
        end
        default: ;
      endcase
    end

    pump1_d = (state_d == StLead && lead_d == LEAD_P1) || state_d == StBoth;
    pump2_d = (state_d == StLead && lead_d == LEAD_P2) || state_d == StBoth;
    alarm_d = (state_d == StFault);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= StIdle;
      off_q   <= '0;
      run_q   <= '0;
      stall_q <= '0;
      lvl_q   <= '0;
      ref_q   <= '0;
      lead_q  <= LEAD_P1;
      cyc_q   <= '0;
      pump1_q <= 1'b0;
      pump2_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      run_q   <= run_d;
      stall_q <= stall_d;
      lvl_q   <= lvl_d;
      ref_q   <= ref_d;
      lead_q  <= lead_d;
      cyc_q   <= cyc_d;
      pump1_q <= pump1_d;
      pump2_q <= pump2_d;
      alarm_q <= alarm_d;
    end
  end

  assign bus.pump1     = pump1_q;
  assign bus.pump2     = pump2_q;
  assign bus.lead_sel  = lead_q;
  assign bus.state     = state_q;
  assign bus.alarm     = alarm_q;
  assign bus.cycle_cnt = cyc_q;
endmodule

// File: tb/tb_pump_lead_lag_scheduler.sv
// Scoreboard bench: each tick's stimulus pushes the model's expected outputs; a
// monitor pops and compares after every decision edge.
module tb_pump_lead_lag_scheduler;
  localparam int Div = 4, MinRun = 5, MinOff = 3, StallT = 8;
  localparam int StartLvl = 64, AssistLvl = 32, StopLvl = 192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pump_lead_lag_scheduler_if bus ();

  pump_lead_lag_scheduler #(
    .TICK_DIV    (Div),
    .MIN_RUN     (16'd5),
    .MIN_OFF     (16'd3),
    .STALL_TICKS (16'd8)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       p1;
    logic       p2;
    logic       lead;
    logic       alarm;
    logic [7:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp, mon_act;
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_cnt;

  // Model state: 0 idle, 1 lead run, 2 both run, 3 fault.
  int m_st, m_lead, m_cyc, m_off, m_run, m_stall, m_ref;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic int sat(int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_lead = 0; m_cyc = 0; m_off = 0; m_run = 0; m_stall = 0; m_ref = 0;
  endfunction

  function automatic void model_step(int lvl, bit en, bit clr);
    case (m_st)
      0: begin
        if (en && lvl <= StartLvl && m_off >= MinOff) begin
          m_st = 1; m_run = 0; m_stall = 0; m_ref = lvl;
        end else m_off = sat(m_off + 1);
      end
      1, 2: begin
        if (!en) begin
          m_st = 0; m_off = 0;
        end else begin
          if (lvl > m_ref) begin m_ref = lvl; m_stall = 0; end
          else m_stall = sat(m_stall + 1);
          if (m_stall >= StallT) m_st = 3;
          else if (lvl >= StopLvl && m_run >= MinRun) begin
            m_st = 0; m_lead = 1 - m_lead; m_off = 0;
            m_cyc = (m_cyc < 255) ? m_cyc + 1 : 255;
          end else if (m_st == 1 && lvl <= AssistLvl) m_st = 2;
          else if (m_st == 2 && lvl > StartLvl) m_st = 1;
          m_run = sat(m_run + 1);
        end
      end
      default: begin
        if (clr) begin m_st = 0; m_off = 0; m_lead = 1 - m_lead; end
      end
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st    = 2'(m_st);
    e.p1    = (m_st == 1 && m_lead == 0) || m_st == 2;
    e.p2    = (m_st == 1 && m_lead == 1) || m_st == 2;
    e.lead  = (m_lead != 0);
    e.alarm = (m_st == 3);
    e.cyc   = 8'(m_cyc);
    return e;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  // Drive one tick's inputs, queue the expectation, return 1 time unit after the
  // decision edge.
  task automatic tick_step(input int lvl, input bit en, input bit clr);
    bus.water_lvl = 8'(lvl);
    bus.enable    = en;
    bus.fault_clr = clr;
    model_step(lvl, en, clr);
    exp_q.push_back(model_out());
    for (int i = 0; i < 2 * Div; i++) begin
      @(posedge clk);
      #1;
      if (edge_cnt % Div == 0) break;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && edge_cnt != 0 && edge_cnt % Div == 0 && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {bus.state, bus.pump1, bus.pump2, bus.lead_sel, bus.alarm, bus.cycle_cnt};
      n_vec++;
      if (mon_act !== mon_exp) begin
        n_err++;
        $display("FAIL tick@%0t: got st=%0d p1=%b p2=%b lead=%b alarm=%b cyc=%0d, expected st=%0d p1=%b p2=%b lead=%b alarm=%b cyc=%0d",
                 $time, mon_act.st, mon_act.p1, mon_act.p2, mon_act.lead, mon_act.alarm,
                 mon_act.cyc, mon_exp.st, mon_exp.p1, mon_exp.p2, mon_exp.lead, mon_exp.alarm,
                 mon_exp.cyc);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pump1"}, 32'(bus.pump1), 0);
    check({tag, "_pump2"}, 32'(bus.pump2), 0);
    check({tag, "_state"}, 32'(bus.state), 0);
    check({tag, "_lead"},  32'(bus.lead_sel), 0);
    check({tag, "_alarm"}, 32'(bus.alarm), 0);
    check({tag, "_cyc"},   32'(bus.cycle_cnt), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl;
    bus.water_lvl = 8'd50;
    bus.enable    = 1'b1;
    bus.fault_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Minimum off time after reset, then lead start on pump1.
    repeat (4) tick_step(50, 1, 0);
    // Fill ramp to the stop level.
    for (int l = 70; l <= 190; l += 20) tick_step(l, 1, 0);
    tick_step(200, 1, 0);
    // Next cycle starts on pump2; assist and hysteresis.
    repeat (4) tick_step(50, 1, 0);
    tick_step(30, 1, 0);
    tick_step(70, 1, 0);
    // Level stuck: stall fault, then clear with one tick of fault_clr.
    repeat (8) tick_step(40, 1, 0);
    tick_step(40, 1, 0);
    tick_step(40, 1, 1);
    // Restart, drop into both-run, then disable.
    repeat (4) tick_step(20, 1, 0);
    tick_step(20, 1, 0);
    tick_step(20, 0, 0);
    // Start again, then reset mid-run between ticks.
    repeat (4) tick_step(50, 1, 0);
    @(negedge clk);
    #2;
    check("pre_rst_pump", 32'(bus.pump1 | bus.pump2), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Stop level reached before the minimum run time.
    repeat (4) tick_step(50, 1, 0);
    repeat (7) tick_step(220, 1, 0);

    // Randomised level walk with occasional disable and fault clear.
    lvl = 40;
    for (int n = 0; n < 400; n++) begin
      lvl = lvl + int'($urandom_range(0, 60)) - 25;
      if ($urandom_range(0, 15) == 0) lvl = int'($urandom_range(0, 255));
      if (lvl < 0) lvl = 0;
      if (lvl > 255) lvl = 255;
      tick_step(lvl, $urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pump_lead_lag_scheduler.md
Name: pump_lead_lag_scheduler

Overview:
Supervisory controller that sequences the two tank pumps from the 8-bit water level bus.
- Lead/lag operation: lead pump starts on low level; lag pump assists on very low level.
- Lead role alternates after every completed fill cycle to equalise wear.
- Enforces minimum run/off times and a no-rise stall fault.
- Sits between the water level source and the pump1/pump2 outputs at the top level.

Parameters:
TICK_DIV, 100000, CLK100MHZ cycles per decision tick (1 kHz); must be >= 2
START_LVL, 8'd64, lead pump starts when level <= this
ASSIST_LVL, 8'd32, lag pump joins when level <= this; must be < START_LVL
STOP_LVL, 8'd192, all pumps stop when level >= this; must be > START_LVL
MIN_RUN, 16'd500, minimum ticks in a run state before a normal stop
MIN_OFF, 16'd200, minimum ticks in IDLE before a restart
STALL_TICKS, 16'd2000, ticks without a level rise while running before FAULT

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  reset, asynchronous, active-low
water_lvl  in  8  current water level (0 = empty, 255 = full)
enable  in  1  scheduler enable; low forces pumps off
fault_clr  in  1  acknowledges FAULT
pump1  out  1  pump 1 run command
pump2  out  1  pump 2 run command
lead_sel  out  1  0 = pump1 is lead, 1 = pump2 is lead
state  out  2  current FSM state code
alarm  out  1  high while in FAULT
cycle_cnt  out  8  completed fill cycles, saturating at 255

Behaviour:
- Single clock domain. Reset is asynchronous, active-low.
- Reset values: state=IDLE, pump1=pump2=0, lead_sel=0, alarm=0, cycle_cnt=0. Internal: tick counter 0, off_timer 0, run_timer 0, stall_timer 0, ref_lvl 0.
  - Consequence: after reset, MIN_OFF ticks must elapse before the first start.
- Tick generation:
  - Counter runs 0..TICK_DIV-1; tick pulses for one cycle at wrap.
  - water_lvl is sampled into lvl_q on tick cycles only.
  - All FSM decisions are made on tick cycles using the freshly sampled value.
- Outputs are registered and change on the clock edge after the deciding tick.
- Pump decode:
  - pump1 = (LEAD_RUN and lead_sel=0) or BOTH_RUN.
  - pump2 = (LEAD_RUN and lead_sel=1) or BOTH_RUN.
- Timers: 16-bit, increment once per tick, saturate at all-ones.
- IDLE (2'd0):
  - Pumps off; off_timer counts.
  - Go to LEAD_RUN when enable=1, lvl<=START_LVL and off_timer>=MIN_OFF.
  - On entry to any run state from IDLE: run_timer=0, stall_timer=0, ref_lvl=lvl.
- LEAD_RUN (2'd1): lead pump on. Per-tick priority:
  1. enable=0 -> IDLE. No lead toggle, no cycle count, off_timer=0.
  2. Stall: if lvl>ref_lvl, set ref_lvl=lvl and stall_timer=0; else increment stall_timer. When stall_timer reaches STALL_TICKS -> FAULT.
  3. lvl>=STOP_LVL and run_timer>=MIN_RUN -> IDLE, toggle lead_sel, increment cycle_cnt (saturating), off_timer=0.
  4. lvl<=ASSIST_LVL -> BOTH_RUN. run_timer and stall tracking continue.
- BOTH_RUN (2'd2): both pumps on.
  - Same priorities 1–3 as LEAD_RUN.
  - Then: lvl>START_LVL -> LEAD_RUN (lag drops; lead unchanged). This provides hysteresis between ASSIST_LVL and START_LVL.
- FAULT (2'd3):
  - Pumps off, alarm=1; enable is ignored.
  - fault_clr=1 on a tick -> IDLE with off_timer=0, alarm=0. lead_sel toggles so the suspect pump is demoted. cycle_cnt unchanged.
- fault_clr outside FAULT: ignored.
- lvl>=STOP_LVL before MIN_RUN has elapsed: the pump keeps running until MIN_RUN is met. The stall check still applies.
- Level at 0 or 255: no special case; comparisons are unsigned.
- Reset asserted mid-run: pumps drop immediately (asynchronous) and all state clears.

Decomposition:
- Shared include pump_sched_defs.vh holds:
  - State codes: ST_IDLE=2'd0, ST_LEAD=2'd1, ST_BOTH=2'd2, ST_FAULT=2'd3.
  - LEAD_P1=1'b0, LEAD_P2=1'b1.
  - Timer width TMR_W=16.
- One sub-module: tick_prescaler. Parameter DIV; ports CLK100MHZ, CPU_RESETN, tick. Reused by the level simulator later.
- FSM, timers and output decode live in the top of this block.

Test Plan (bench params: TICK_DIV=4, MIN_RUN=5, MIN_OFF=3, STALL_TICKS=8, defaults otherwise):
- Reset then water_lvl=50, enable=1 -> pump1=0 for 3 ticks. pump1=1 after the 4th tick; lead_sel=0, state=1.
- Level ramps +20 per tick from 50 to 200 -> pumps stop the cycle after the 200 sample (run_timer>=5). lead_sel=1, cycle_cnt=1. The next start drives pump2.
- During LEAD_RUN, drop level to 30 -> state=2 and both pumps on. Raise to 70 -> state=1 with only the lead pump on.
- Hold level at 40 while running -> state=3, pumps off and alarm=1 after 8 ticks. Pulse fault_clr for a full tick -> state=0, alarm=0, lead_sel toggled.
- Deassert enable in BOTH_RUN -> IDLE on the next tick with pumps off; lead_sel and cycle_cnt unchanged.
- Assert CPU_RESETN=0 mid-run, between ticks -> pump1/pump2 go to 0 without waiting for a clock edge; all outputs return to reset values.
